// File: rtl/cnn_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cnn_pkg: shared constants and types for the cnn_conv3x3 engine.  Rev 1.0
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam logic [6:0]  IN_W  = 7'd66;
  localparam logic [6:0]  IMG_W = 7'd64;
  localparam logic [3:0]  N_W   = 4'd9;
  localparam logic [12:0] N_PIX = 13'd4356;
  localparam logic [12:0] N_OUT = 13'd4096;

  localparam int ACC_W          = 20;
  localparam int OUT_SHIFT_DFLT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [7:0]              pix_t;
  typedef logic signed [7:0]       wgt_t;
  typedef logic signed [ACC_W-1:0] acc_t;

endpackage
`default_nettype wire

// File: rtl/cnn_line_window.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cnn_line_window: two line buffers plus 3x3 window over a padded raster stream.
// Rev 1.0
// -----------------------------------------------------------------------------
module cnn_line_window import cnn_pkg::*; #(
  parameter logic [6:0] LINE_W = IN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pix_t            pix_i,
  input  logic            pix_valid_i,
  output logic [8:0][7:0] win_o,
  output logic            win_valid_o,
  output logic [5:0]      out_row_o,
  output logic [5:0]      out_col_o
);

  logic [6:0]      col_q, col_d, row_q, row_d;
  logic [8:0][7:0] win_q, win_d;
  logic            win_valid_q, win_valid_d;
  logic [5:0]      out_row_q, out_row_d, out_col_q, out_col_d;

  // lb_top holds input row-2, lb_mid holds row-1, both indexed by column
  pix_t lb_top [0:LINE_W-1];
  pix_t lb_mid [0:LINE_W-1];
  pix_t top_pix, mid_pix;

  assign top_pix = lb_top[col_q];
  assign mid_pix = lb_mid[col_q];

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (pix_valid_i) begin
      for (int kr = 0; kr < 3; kr++) begin
        win_d[3*kr]   = win_q[3*kr+1];
        win_d[3*kr+1] = win_q[3*kr+2];
      end
      win_d[2]    = top_pix;
      win_d[5]    = mid_pix;
      win_d[8]    = pix_i;
      win_valid_d = (row_q >= 7'd2) && (col_q >= 7'd2);
      out_row_d   = 6'(row_q - 7'd2);
      out_col_d   = 6'(col_q - 7'd2);
      if (col_q == LINE_W - 7'd1) begin
        col_d = 7'd0;
        row_d = (row_q == LINE_W - 7'd1) ? 7'd0 : row_q + 7'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  // Line storage needs no reset: rows 0-1 are rewritten before any window uses them
  always_ff @(posedge clk) begin
    if (pix_valid_i) begin
      lb_top[col_q] <= mid_pix;
      lb_mid[col_q] <= pix_i;
    end
  end

  assign win_o       = win_q;
  assign win_valid_o = win_valid_q;
  assign out_row_o   = out_row_q;
  assign out_col_o   = out_col_q;

endmodule
`default_nettype wire

// File: rtl/cnn_conv3x3.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cnn_conv3x3: 3x3 correlation over a padded 66x66 stream, 8-bit saturated output.
// Define CNN_RELU_EN for unsigned ReLU output instead of signed.  Rev 1.0
// -----------------------------------------------------------------------------
module cnn_conv3x3 import cnn_pkg::*; #(
  parameter int OUT_SHIFT = OUT_SHIFT_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        image_ready,
  output logic        image_rden_o,
  output logic [12:0] image_addr_o,
  input  logic [7:0]  image_i,
  input  logic        image_valid,
  output logic        filter_rden_o,
  output logic [3:0]  filter_addr_o,
  input  logic [7:0]  filter_i,
  input  logic        filter_valid,
  output logic        cnn_valid_o,
  output logic [7:0]  cnn_data_o
);

  state_t      state_q, state_d;
  logic [12:0] rd_cnt_q, rd_cnt_d;
  logic [3:0]  wcnt_q, wcnt_d;
  wgt_t        w_q [0:8];
  wgt_t        w_d [0:8];
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;

  logic [8:0][7:0] win;
  logic            win_valid;
  logic [5:0]      out_row, out_col;
  logic            pix_valid;
  acc_t            acc, shifted;
  logic [7:0]      sat;

  // Late valids from an aborted or finished run never reach the window
  assign pix_valid = image_valid && (state_q == STREAM);

  cnn_line_window #(.LINE_W(IN_W)) u_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_i       (image_i),
    .pix_valid_i (pix_valid),
    .win_o       (win),
    .win_valid_o (win_valid),
    .out_row_o   (out_row),
    .out_col_o   (out_col)
  );

  assign image_rden_o  = (state_q == STREAM) && (rd_cnt_q < N_PIX);
  assign image_addr_o  = image_rden_o ? rd_cnt_q : '0;
  assign filter_rden_o = (state_q == LOAD_W) && (rd_cnt_q < {9'd0, N_W});
  assign filter_addr_o = filter_rden_o ? rd_cnt_q[3:0] : '0;

  always_comb begin
    acc = '0;
    for (int k = 0; k < 9; k++) begin
      acc = acc + acc_t'($signed({1'b0, win[k]})) * acc_t'(w_q[k]);
    end
    shifted = acc >>> OUT_SHIFT;
`ifdef CNN_RELU_EN
    if (acc < 0)                      sat = 8'h00;
    else if (shifted > acc_t'(255))   sat = 8'hFF;
    else                              sat = shifted[7:0];
`else
    if (shifted > acc_t'(127))        sat = 8'h7F;
    else if (shifted < acc_t'(-128))  sat = 8'h80;
    else                              sat = shifted[7:0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wcnt_d   = wcnt_q;
    w_d      = w_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (image_ready) begin
          state_d  = LOAD_W;
          rd_cnt_d = '0;
          wcnt_d   = '0;
        end
      end
      LOAD_W: begin
        if (filter_rden_o) rd_cnt_d = rd_cnt_q + 13'd1;
        if (filter_valid) begin
          w_d[wcnt_q] = wgt_t'(filter_i);
          wcnt_d      = wcnt_q + 4'd1;
          if (wcnt_q == N_W - 4'd1) begin
            state_d  = STREAM;
            rd_cnt_d = '0;
          end
        end
      end
      STREAM: begin
        if (image_rden_o) rd_cnt_d = rd_cnt_q + 13'd1;
        if (win_valid) begin
          valid_d = 1'b1;
          data_d  = sat;
          if ({out_row, out_col} == 12'(N_OUT - 13'd1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      wcnt_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      for (int k = 0; k < 9; k++) w_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wcnt_q   <= wcnt_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      w_q      <= w_d;
    end
  end

  assign cnn_valid_o = valid_q;
  assign cnn_data_o  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_conv3x3.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_cnn_conv3x3: directed and random image runs against a full-frame reference.
// -----------------------------------------------------------------------------
module tb_cnn_conv3x3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        image_ready = 1'b0;
  logic        image_rden_o;
  logic [12:0] image_addr_o;
  logic [7:0]  image_i = 8'h00;
  logic        image_valid = 1'b0;
  logic        filter_rden_o;
  logic [3:0]  filter_addr_o;
  logic [7:0]  filter_i = 8'h00;
  logic        filter_valid = 1'b0;
  logic        cnn_valid_o;
  logic [7:0]  cnn_data_o;

  cnn_conv3x3 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .image_ready   (image_ready),
    .image_rden_o  (image_rden_o),
    .image_addr_o  (image_addr_o),
    .image_i       (image_i),
    .image_valid   (image_valid),
    .filter_rden_o (filter_rden_o),
    .filter_addr_o (filter_addr_o),
    .filter_i      (filter_i),
    .filter_valid  (filter_valid),
    .cnn_valid_o   (cnn_valid_o),
    .cnn_data_o    (cnn_data_o)
  );

  always #5 clk = ~clk;

  logic [7:0]        img  [0:4355];
  logic signed [7:0] wmem [0:8];
  logic [7:0]        exp_out [0:4095];

  // Synchronous memories: data and valid one cycle after the read enable
  always @(posedge clk) begin
    image_valid  <= image_rden_o;
    image_i      <= (image_rden_o && image_addr_o < 13'd4356) ? img[image_addr_o] : 8'h00;
    filter_valid <= filter_rden_o;
    filter_i     <= (filter_rden_o && filter_addr_o < 4'd9) ? wmem[filter_addr_o] : 8'h00;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got [$];
  int got_cyc [$];
  int vcyc [$];
  int img_exp_addr, flt_exp_addr, addr_err, img_first, img_last;

  always @(negedge clk) begin
    if (image_valid) vcyc.push_back(cyc);
    if (cnn_valid_o) begin
      got.push_back(cnn_data_o);
      got_cyc.push_back(cyc);
    end
    if (image_rden_o) begin
      if (image_addr_o != 13'(img_exp_addr)) addr_err++;
      img_exp_addr++;
      if (img_first < 0) img_first = cyc;
      img_last = cyc;
    end
    if (filter_rden_o) begin
      if (filter_addr_o != 4'(flt_exp_addr)) addr_err++;
      flt_exp_addr++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] got_at(input int n);
    if (n < got.size()) return {24'd0, got[n]};
    return 32'hxxxxxxxx;
  endfunction

  // mode 0: constant interior, zero pad; 1: constant everywhere;
  // 2: interior R+C, zero pad; other: random interior, zero pad
  task automatic set_img(input int mode, input logic [7:0] v);
    logic [7:0] p;
    bit pad;
    for (int r = 0; r < 66; r++) begin
      for (int c = 0; c < 66; c++) begin
        pad = (r == 0) || (r == 65) || (c == 0) || (c == 65);
        case (mode)
          0:       p = pad ? 8'h00 : v;
          1:       p = v;
          2:       p = pad ? 8'h00 : 8'(r + c);
          default: p = pad ? 8'h00 : 8'($urandom_range(0, 255));
        endcase
        img[r*66+c] = p;
      end
    end
  endtask

  // mode 0: all v; 1: 8 at centre only; other: random
  task automatic set_w(input int mode, input logic [7:0] v);
    for (int k = 0; k < 9; k++) begin
      case (mode)
        0:       wmem[k] = v;
        1:       wmem[k] = (k == 4) ? 8'sd8 : 8'sd0;
        default: wmem[k] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic model();
    int acc, s;
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        acc = 0;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            acc += int'(img[(r+kr)*66 + c + kc]) * int'(wmem[3*kr+kc]);
        s = acc >>> 4;
`ifdef CNN_RELU_EN
        if (acc < 0) s = 0;
        else if (s > 255) s = 255;
`else
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
`endif
        exp_out[r*64+c] = 8'(s);
      end
    end
  endtask

  task automatic clear_mon();
    got.delete();
    got_cyc.delete();
    vcyc.delete();
    img_exp_addr = 0;
    flt_exp_addr = 0;
    addr_err     = 0;
    img_first    = -1;
    img_last     = -1;
  endtask

  task automatic run_image(input string tag, input bit glitch);
    int start, mism, tim, idx, lat;
    bit fired;
    model();
    clear_mon();
    fired = 1'b0;
    @(negedge clk);
    image_ready = 1'b1;
    start = cyc + 1;
    @(negedge clk);
    image_ready = 1'b0;
    for (int i = 0; i < 5000 && got.size() < 4096; i++) begin
      if (glitch && !fired && got.size() >= 50) begin
        image_ready = 1'b1;
        fired = 1'b1;
      end else begin
        image_ready = 1'b0;
      end
      @(negedge clk);
    end
    image_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk({tag, ":count"}, got.size(), 4096);
    mism = 0;
    tim  = 0;
    for (int n = 0; n < got.size() && n < 4096; n++) begin
      if (got[n] !== exp_out[n]) mism++;
      idx = ((n / 64) + 2) * 66 + (n % 64) + 2;
      if (idx >= vcyc.size()) tim++;
      else if (got_cyc[n] != vcyc[idx] + 2) tim++;
    end
    chk({tag, ":data_mismatches"}, mism, 0);
    chk({tag, ":timing_errors"}, tim, 0);
    chk({tag, ":addr_errors"}, addr_err, 0);
    chk({tag, ":img_reads"}, img_exp_addr, 4356);
    chk({tag, ":flt_reads"}, flt_exp_addr, 9);
    chk({tag, ":img_read_span"}, img_last - img_first + 1, 4356);
    lat = (got.size() > 0) ? got_cyc[got.size()-1] - start : 99999;
    chk({tag, ":latency_ok"}, {31'd0, lat <= 4400}, 1);
    chk({tag, ":idle_after"}, {29'd0, image_rden_o, filter_rden_o, cnn_valid_o}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    set_img(0, 8'd0);
    set_w(0, 8'd0);
    clear_mon();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst:cnn_valid", cnn_valid_o, 0);
    chk("rst:cnn_data", cnn_data_o, 0);
    chk("rst:rden", {image_rden_o, filter_rden_o}, 0);
    chk("rst:addr", {image_addr_o, filter_addr_o}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle:no_reads", {image_rden_o, filter_rden_o, cnn_valid_o}, 0);

    // All 16, unit weights: interior 9, corner 4
    set_img(0, 8'd16);
    set_w(0, 8'd1);
    run_image("ones", 1'b0);
    chk("ones:corner", got_at(0), 4);
    chk("ones:interior", got_at(10*64+10), 9);
    chk("ones:edge", got_at(5), 6);

    // Centre weight 8 over a diagonal ramp
    set_img(2, 8'd0);
    set_w(1, 8'd0);
    run_image("ramp", 1'b0);
    chk("ramp:out0_0", got_at(0), 1);
    chk("ramp:out63_63", got_at(4095), 64);
    chk("ramp:out20_7", got_at(20*64+7), 14);

    // Negative saturation / ReLU clamp
    set_img(1, 8'd255);
    set_w(0, 8'hFF);
    run_image("neg", 1'b0);
`ifdef CNN_RELU_EN
    chk("neg:sample", got_at(1234), 8'h00);
`else
    chk("neg:sample", got_at(1234), 8'h80);
`endif

    // Positive saturation
    set_img(1, 8'd255);
    set_w(0, 8'd127);
    run_image("pos", 1'b0);
`ifdef CNN_RELU_EN
    chk("pos:sample", got_at(2222), 8'hFF);
`else
    chk("pos:sample", got_at(2222), 8'h7F);
`endif

    // Random images and weights
    set_img(3, 8'd0);
    set_w(2, 8'd0);
    run_image("rand1", 1'b0);
    set_img(3, 8'd0);
    set_w(2, 8'd0);
    run_image("rand2", 1'b0);

    // Abort mid-stream with reset, then a complete fresh run
    set_img(3, 8'd0);
    set_w(2, 8'd0);
    clear_mon();
    @(negedge clk);
    image_ready = 1'b1;
    @(negedge clk);
    image_ready = 1'b0;
    for (int i = 0; i < 1000 && got.size() < 100; i++) @(negedge clk);
    chk("abort:streaming", image_rden_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort:valid_low", cnn_valid_o, 0);
    chk("abort:rden_low", {image_rden_o, filter_rden_o}, 0);
    repeat (3) @(negedge clk);
    n_before = got.size();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort:no_more_outputs", got.size(), n_before);
    chk("abort:idle_rden", {image_rden_o, filter_rden_o}, 0);
    set_img(3, 8'd0);
    set_w(2, 8'd0);
    run_image("after_abort", 1'b0);

    // image_ready pulsed mid-stream must be ignored
    set_img(3, 8'd0);
    set_w(2, 8'd0);
    run_image("glitch", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
